mc_datapath_p: RTL and testbench
================================

# mc_datapath_p

Parametrised multicycle datapath for the ARM-subset core. It sits between the multicycle control FSM and the unified instruction/data memory. Relative to the current fixed 32-bit datapath it adds:
- configurable data width and register count;
- a registered memory-data stage with a memory-ready handshake;
- an operand barrel shifter;
- an extended ALU op set;
- an architectural NZCV flag register with split write enables.

## Interface
Parameters:
- WIDTH, 32, datapath width; legal values 32 or 64
- NREGS, 16, register count, power of two, ≥8; the top index is the PC alias
- PC_RESET, 0, PC value after reset
- PC_OFFSET, 8, value added to PC when the top register is read

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Adr  out  WIDTH  memory address
- WriteData  out  WIDTH  store data (WD register)
- ReadData  in  WIDTH  memory read data
- MemReady  in  1  memory has completed the current access; low = stall
- Instr  out  32  instruction register
- ALUFlags  out  4  combinational NZCV from the current ALU/shift result
- Flags  out  4  registered architectural NZCV
- PCWrite, RegWrite, IRWrite, AdrSrc  in  1 each  control strobes
- RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  in  2 each  mux selects
- ALUControl  in  3  ALU op
- FlagWrite  in  2  bit1 writes N and Z; bit0 writes C and V
- ShiftEn  in  1  apply the Instr shift field to the register operand

## Operation
- **Stall rule**
  - MemReady=0 suppresses PC, IR, regfile, Flags, Data, A, WD and ALUOut updates; all hold.
  - MemReady=1 gives normal operation.
- **Strobed registers**
  - IR loads ReadData[31:0] when IRWrite.
  - PC loads Result when PCWrite.
- **Data register**: loads ReadData every unstalled cycle.
- **Register file**
  - RA1 = RegSrc[0] ? NREGS-1 : Instr[19:16].
  - RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
  - Only the low log2(NREGS) bits of each field are used.
  - Reading index NREGS-1 returns PC+PC_OFFSET.
  - A write to Instr[15:12] is dropped if it targets NREGS-1.
- **A / WD registers**: load RD1 and RD2 every unstalled cycle.
- **Extend**
  - ImmSrc 00: zero-extend Instr[7:0].
  - ImmSrc 01: zero-extend Instr[11:0].
  - ImmSrc 10: sign-extend Instr[23:0] and shift left by 2.
  - ImmSrc 11: zero.
- **SrcA**: 00 PC, 01 A, 10 zero, 11 zero.
- **SrcB**: 00 shifted WD, 01 ExtImm, 10 constant 4, 11 zero.
- **Shifter** (applies only when ShiftEn=1 and ALUSrcB=00)
  - Type from Instr[6:5]: LSL, LSR, ASR, ROR. Amount from Instr[11:7].
  - Amount 0 passes the operand through, with carry = Flags.C.
  - Shifter carry = last bit shifted out.
- **ALU**
  - 000 ADD, 001 SUB (a−b), 010 AND, 011 ORR, 100 EOR, 101 MOV (b), 11x ADD.
  - N = result[WIDTH-1]; Z = result==0.
  - ADD/SUB: C = carry out (for SUB, C = no borrow); V = signed overflow.
  - Logical ops and MOV: C = shifter carry; V = Flags.V, so V is unchanged on write-back.
- **ALUOut**: loads ALUResult every unstalled cycle.
- **Result**: 00 ALUResult, 01 ALUOut, 10 Data register, 11 ExtImm.
- **Adr** = AdrSrc ? ALUOut : PC.

## Timing
- All state updates on the rising clk edge; Adr, ALUFlags and Result are combinational.
- Register-file write and read of the same index in the same cycle: the read returns the old value; the new value is visible the next cycle.
- PCWrite together with a read of the top register: the read returns old PC+PC_OFFSET.
- Load path latency: ReadData captured at edge N is usable via ResultSrc=10 in cycle N+1.
- Reset (asynchronous, at any time including mid-stall) clears state immediately:
  - PC = PC_RESET;
  - IR, A, WD, ALUOut, Data, Flags and all registers = 0;
  - outputs Adr = PC_RESET when AdrSrc=0, WriteData = 0, Instr = 0, Flags = 0.
- MemReady affects only the next edge; a stall of any length followed by MemReady=1 completes the held access exactly once.

## Structure
- Package mc_dp_pkg holds:
  - ALU op encodings;
  - shift-type encodings;
  - SrcA, SrcB, Result and ImmSrc select encodings;
  - flag bit indices (N=3, Z=2, C=1, V=0).
- One sub-module, dp_shifter (WIDTH-parametrised barrel shifter with carry out).
- Existing flop and mux primitives are reused with WIDTH.

## Test plan
- **Reset**: assert reset mid-cycle with PC_RESET=0x100 → Adr=0x100, Flags=0, Instr=0 immediately, before any clock edge.
- **Fetch**: ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=00, PCWrite=1, IRWrite=1, ReadData=0xE0810002 → next edge Instr=0xE0810002, PC=PC+4.
- **Stall**: hold MemReady=0 for 3 cycles during fetch → PC and IR unchanged; raise MemReady → exactly one PC+4 and one IR load.
- **Shift**:
  - R2=0x80000001, Instr shift ROR #1, MOV with FlagWrite=11 → result 0xC0000000, Flags N=1 Z=0 C=1, V unchanged.
  - Same operand, shift LSL #0 → result 0x80000001, C unchanged.
- **Subtract flags**: SUB with A=5 and b=5 → result 0, Z=1, C=1, V=0; SUB with A=0x80000000 and b=1 → V=1, N=0.
- **Load and R15 write**
  - Load with ReadData=0xDEADBEEF, then ResultSrc=10 with RegWrite → Rd=0xDEADBEEF.
  - RegWrite targeting index 15 → no register changes; reading R15 returns PC+8.

Source files
------------

// File: rtl/mc_dp_pkg.sv
// Shared encodings for the parametrised multicycle datapath: ALU ops, shift types,
// operand/result/immediate selects and NZCV bit positions.
package mc_dp_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_ORR  = 3'b011,
        ALU_EOR  = 3'b100,
        ALU_MOV  = 3'b101,
        ALU_ADD6 = 3'b110,
        ALU_ADD7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_A     = 2'b01,
        SRCA_ZERO  = 2'b10,
        SRCA_ZERO3 = 2'b11
    } srca_e;

    typedef enum logic [1:0] {
        SRCB_WD   = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        RES_ALU    = 2'b00,
        RES_ALUOUT = 2'b01,
        RES_DATA   = 2'b10,
        RES_IMM    = 2'b11
    } res_e;

    typedef enum logic [1:0] {
        IMM_8    = 2'b00,
        IMM_12   = 2'b01,
        IMM_BR   = 2'b10,
        IMM_ZERO = 2'b11
    } imm_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/dp_shifter.sv
// Combinational barrel shifter for the register operand; carry is the last bit
// shifted out, or the incoming carry when the amount is zero.
module dp_shifter
    import mc_dp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       sh_type,
    input  logic [4:0]       amt,
    input  logic             cin,
    output logic [WIDTH-1:0] y_c,
    output logic             cout_c
);

    logic [WIDTH:0]   lsl_w;
    logic [WIDTH:0]   lsr_w;
    logic [WIDTH:0]   asr_w;
    logic [WIDTH-1:0] ror_w;

    // One extra bit on the shifted-out side captures the carry directly.
    assign lsl_w = {1'b0, a} << amt;
    assign lsr_w = {a, 1'b0} >> amt;
    assign asr_w = $signed({a, 1'b0}) >>> amt;
    assign ror_w = (a >> amt) | (a << (7'(WIDTH) - 7'(amt)));

    always_comb begin
        y_c    = a;
        cout_c = cin;
        if (amt != 5'd0) begin
            case (sh_type)
                SH_LSL: begin
                    y_c    = lsl_w[WIDTH-1:0];
                    cout_c = lsl_w[WIDTH];
                end
                SH_LSR: begin
                    y_c    = lsr_w[WIDTH:1];
                    cout_c = lsr_w[0];
                end
                SH_ASR: begin
                    y_c    = asr_w[WIDTH:1];
                    cout_c = asr_w[0];
                end
                default: begin
                    y_c    = ror_w;
                    cout_c = ror_w[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_datapath_p.sv
// Parametrised multicycle datapath: regfile with PC alias, operand shifter, ALU with
// NZCV, registered memory-data stage and a MemReady stall that freezes all state.
module mc_datapath_p
    import mc_dp_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     NREGS     = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter int unsigned     PC_OFFSET = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData,
    input  logic             MemReady,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       Flags,
    input  logic             PCWrite,
    input  logic             RegWrite,
    input  logic             IRWrite,
    input  logic             AdrSrc,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       ImmSrc,
    input  logic [2:0]       ALUControl,
    input  logic [1:0]       FlagWrite,
    input  logic             ShiftEn
);

    localparam int unsigned   AW  = $clog2(NREGS);
    localparam logic [AW-1:0] TOP = AW'(NREGS - 1);

    logic [WIDTH-1:0] pc;
    logic [31:0]      ir;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] wd_q;
    logic [WIDTH-1:0] aluout_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] rf [NREGS];

    logic [AW-1:0]    ra1, ra2, wa3;
    logic [WIDTH-1:0] pc_plus, rd1, rd2;
    logic [WIDTH-1:0] ext_imm, src_a, src_b, b_eff, result, alu_res;
    logic [WIDTH-1:0] sh_y;
    logic             sh_c, shift_act, op_c;
    logic [WIDTH:0]   sum;
    logic             alu_sub, alu_c, alu_v;
    logic [3:0]       alu_flags;

    // Register reads; the top index aliases to PC plus the pipeline offset.
    assign ra1     = RegSrc[0] ? TOP : AW'(ir[19:16]);
    assign ra2     = RegSrc[1] ? AW'(ir[15:12]) : AW'(ir[3:0]);
    assign wa3     = AW'(ir[15:12]);
    assign pc_plus = pc + WIDTH'(PC_OFFSET);
    assign rd1     = (ra1 == TOP) ? pc_plus : rf[ra1];
    assign rd2     = (ra2 == TOP) ? pc_plus : rf[ra2];

    always_comb begin
        ext_imm = '0;
        case (ImmSrc)
            IMM_8:   ext_imm = WIDTH'(ir[7:0]);
            IMM_12:  ext_imm = WIDTH'(ir[11:0]);
            IMM_BR:  ext_imm = {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    dp_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a       (wd_q),
        .sh_type (ir[6:5]),
        .amt     (ir[11:7]),
        .cin     (flags_q[FLAG_C]),
        .y_c     (sh_y),
        .cout_c  (sh_c)
    );

    assign shift_act = ShiftEn && (ALUSrcB == SRCB_WD);
    assign op_c      = shift_act ? sh_c : flags_q[FLAG_C];

    always_comb begin
        src_a = '0;
        case (ALUSrcA)
            SRCA_PC: src_a = pc;
            SRCA_A:  src_a = a_q;
            default: src_a = '0;
        endcase
        src_b = '0;
        case (ALUSrcB)
            SRCB_WD:   src_b = shift_act ? sh_y : wd_q;
            SRCB_IMM:  src_b = ext_imm;
            SRCB_FOUR: src_b = WIDTH'(4);
            default:   src_b = '0;
        endcase
    end

    // Subtraction reuses the adder as a + ~b + 1, so carry means "no borrow".
    assign alu_sub = (ALUControl == ALU_SUB);
    assign b_eff   = alu_sub ? ~src_b : src_b;
    assign sum     = {1'b0, src_a} + {1'b0, b_eff} + (WIDTH+1)'(alu_sub);

    always_comb begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
        case (ALUControl)
            ALU_AND, ALU_ORR, ALU_EOR, ALU_MOV: begin
                alu_c = op_c;
                alu_v = flags_q[FLAG_V];
                case (ALUControl)
                    ALU_AND: alu_res = src_a & src_b;
                    ALU_ORR: alu_res = src_a | src_b;
                    ALU_EOR: alu_res = src_a ^ src_b;
                    default: alu_res = src_b;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};

    always_comb begin
        result = '0;
        case (ResultSrc)
            RES_ALU:    result = alu_res;
            RES_ALUOUT: result = aluout_q;
            RES_DATA:   result = data_q;
            default:    result = ext_imm;
        endcase
    end

    // All architectural state holds while the memory is not ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= PC_RESET;
            ir       <= '0;
            data_q   <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            aluout_q <= '0;
            flags_q  <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (MemReady) begin
            data_q   <= ReadData;
            a_q      <= rd1;
            wd_q     <= rd2;
            aluout_q <= alu_res;
            if (PCWrite) pc <= result;
            if (IRWrite) ir <= ReadData[31:0];
            if (RegWrite && (wa3 != TOP)) rf[wa3] <= result;
            if (FlagWrite[1]) begin
                flags_q[FLAG_N] <= alu_flags[FLAG_N];
                flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (FlagWrite[0]) begin
                flags_q[FLAG_C] <= alu_flags[FLAG_C];
                flags_q[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    assign Adr       = AdrSrc ? aluout_q : pc;
    assign WriteData = wd_q;
    assign Instr     = ir;
    assign ALUFlags  = alu_flags;
    assign Flags     = flags_q;

endmodule

// File: tb/tb_mc_datapath_p.sv
// Directed bench for mc_datapath_p: ALU vector table plus fetch/stall, shifter flags,
// load/PC-alias and asynchronous-reset sequences.
module tb_mc_datapath_p;
    import mc_dp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Adr, WriteData, ReadData, Instr;
    logic        MemReady;
    logic [3:0]  ALUFlags, Flags;
    logic        PCWrite, RegWrite, IRWrite, AdrSrc, ShiftEn;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, FlagWrite;
    logic [2:0]  ALUControl;

    always #5 clk = ~clk;

    mc_datapath_p #(
        .WIDTH(32), .NREGS(16), .PC_RESET(32'h100), .PC_OFFSET(8)
    ) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData),
        .ReadData(ReadData), .MemReady(MemReady), .Instr(Instr),
        .ALUFlags(ALUFlags), .Flags(Flags), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .FlagWrite(FlagWrite), .ShiftEn(ShiftEn)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vecs [12];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemReady = 1'b1; PCWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0;
        AdrSrc = 1'b0; ShiftEn = 1'b0; RegSrc = 2'b00; ALUSrcA = 2'b00;
        ALUSrcB = 2'b00; ResultSrc = 2'b00; ImmSrc = 2'b00; FlagWrite = 2'b00;
        ALUControl = 3'b000;
    endtask

    task automatic load_ir(input logic [31:0] ins);
        IRWrite = 1'b1; ReadData = ins;
        tick();
        IRWrite = 1'b0;
    endtask

    // Write via the load path: Data captures val, then ResultSrc=10 writes Rd.
    task automatic write_reg(input logic [3:0] rd, input logic [31:0] val);
        load_ir({12'hE08, 4'h1, rd, 12'h002});
        ReadData = val;
        tick();
        ResultSrc = 2'b10; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0; ResultSrc = 2'b00;
    endtask

    // R1=a, R2=b, then op on A and (optionally shifted) WD; result read via ALUOut on Adr.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [11:0] low12,
                          input logic [2:0] op, input logic sen, input logic [1:0] fw,
                          output logic [31:0] res, output logic [3:0] nzcv);
        write_reg(4'd1, a);
        write_reg(4'd2, b);
        load_ir({12'hE1A, 4'h1, 4'h0, low12});
        tick();
        ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUControl = op; ShiftEn = sen; FlagWrite = fw;
        #1 nzcv = ALUFlags;
        tick();
        FlagWrite = 2'b00; ShiftEn = 1'b0; AdrSrc = 1'b1;
        #1 res = Adr;
        idle();
    endtask

    task automatic read_reg(input logic [3:0] rn, output logic [31:0] val);
        load_ir({12'hE08, rn, 4'h0, 12'h000});
        tick();
        ALUSrcA = 2'b01; ALUSrcB = 2'b11; ALUControl = ALU_ADD;
        tick();
        AdrSrc = 1'b1;
        #1 val = Adr;
        idle();
    endtask

    initial begin
        logic [31:0] res, v;
        logic [3:0]  nz;

        vecs[0]  = '{ALU_ADD,  32'd5,         32'd3,         32'd8,         4'b0000};
        vecs[1]  = '{ALU_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,         4'b0110};
        vecs[2]  = '{ALU_ADD,  32'h7FFFFFFF,  32'd1,         32'h80000000,  4'b1001};
        vecs[3]  = '{ALU_SUB,  32'd5,         32'd5,         32'd0,         4'b0110};
        vecs[4]  = '{ALU_SUB,  32'h80000000,  32'd1,         32'h7FFFFFFF,  4'b0011};
        vecs[5]  = '{ALU_SUB,  32'd3,         32'd5,         32'hFFFFFFFE,  4'b1000};
        vecs[6]  = '{ALU_AND,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  4'b1000};
        vecs[7]  = '{ALU_ORR,  32'h0F0F0000,  32'h000000F0,  32'h0F0F00F0,  4'b0000};
        vecs[8]  = '{ALU_EOR,  32'hAAAA5555,  32'hAAAA5555,  32'd0,         4'b0100};
        vecs[9]  = '{ALU_MOV,  32'h00000099,  32'h12345678,  32'h12345678,  4'b0000};
        vecs[10] = '{ALU_ADD6, 32'd1,         32'd2,         32'd3,         4'b0000};
        vecs[11] = '{ALU_ADD7, 32'h80000000,  32'h80000000,  32'd0,         4'b0111};

        idle();
        ReadData = 32'h0;
        reset = 1'b1;
        #2;
        check("reset_adr", Adr, 32'h100);
        check("reset_instr", Instr, 32'h0);
        check("reset_flags", 32'(Flags), 32'h0);
        check("reset_wd", WriteData, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, 12'h002, vecs[i].op, 1'b0, 2'b00, res, nz);
            check($sformatf("vec%0d_res", i), res, vecs[i].res);
            check($sformatf("vec%0d_nzcv", i), 32'(nz), 32'(vecs[i].nzcv));
        end

        // Fetch: PC+4 into PC, ReadData into IR.
        ALUSrcA = 2'b00; ALUSrcB = 2'b10; ALUControl = ALU_ADD; ResultSrc = 2'b00;
        PCWrite = 1'b1; IRWrite = 1'b1; ReadData = 32'hE0810002;
        tick();
        check("fetch_instr", Instr, 32'hE0810002);
        check("fetch_pc", Adr, 32'h104);

        MemReady = 1'b0; ReadData = 32'h11111111;
        repeat (3) tick();
        check("stall_pc", Adr, 32'h104);
        check("stall_instr", Instr, 32'hE0810002);
        MemReady = 1'b1;
        tick();
        check("resume_pc", Adr, 32'h108);
        check("resume_instr", Instr, 32'h11111111);
        PCWrite = 1'b0; IRWrite = 1'b0;
        tick();
        check("resume_once_pc", Adr, 32'h108);
        idle();

        run_op(32'd5, 32'd5, 12'h002, ALU_SUB, 1'b0, 2'b11, res, nz);
        check("sub_eq_res", res, 32'h0);
        check("sub_eq_flags", 32'(Flags), 32'h6);
        run_op(32'h80000000, 32'd1, 12'h002, ALU_SUB, 1'b0, 2'b11, res, nz);
        check("sub_ovf_res", res, 32'h7FFFFFFF);
        check("sub_ovf_flags", 32'(Flags), 32'h3);
        run_op(32'd0, 32'h80000001, 12'h0E2, ALU_MOV, 1'b1, 2'b11, res, nz);
        check("ror1_res", res, 32'hC0000000);
        check("ror1_aluflags", 32'(nz), 32'hB);
        check("ror1_flags", 32'(Flags), 32'hB);
        run_op(32'h7FFFFFFF, 32'd1, 12'h002, ALU_ADD, 1'b0, 2'b11, res, nz);
        check("add_ovf_flags", 32'(Flags), 32'h9);
        run_op(32'd0, 32'h80000001, 12'h002, ALU_MOV, 1'b1, 2'b11, res, nz);
        check("lsl0_res", res, 32'h80000001);
        check("lsl0_flags", 32'(Flags), 32'h9);
        run_op(32'd5, 32'd5, 12'h002, ALU_SUB, 1'b0, 2'b10, res, nz);
        check("nz_only_flags", 32'(Flags), 32'h5);

        write_reg(4'd3, 32'hDEADBEEF);
        read_reg(4'd3, v);
        check("load_r3", v, 32'hDEADBEEF);
        write_reg(4'd15, 32'h55555555);
        read_reg(4'd3, v);
        check("r15_write_r3", v, 32'hDEADBEEF);
        read_reg(4'd15, v);
        check("r15_read_pc8", v, 32'h110);

        // Asynchronous reset in mid-cycle.
        #2 reset = 1'b1;
        #1;
        check("areset_adr", Adr, 32'h100);
        check("areset_instr", Instr, 32'h0);
        check("areset_flags", 32'(Flags), 32'h0);
        check("areset_wd", WriteData, 32'h0);
        #3 reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
